// File: rtl/alu16_sched_pkg.sv
// Shared types for the two-requester scheduler that time-multiplexes a 16-bit ALU.
// Wide (32-bit) operations run as two chained 16-bit passes.
package alu16_sched_pkg;

   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      RESP = 2'd3
   } state_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  opcode;
      logic        mode;
      logic        cin;
      logic        wide;
   } req_t;

endpackage

// File: rtl/alu16_rr_arb.sv
// Two-way round-robin arbiter.
// The pointer moves only when the granted operation has fully completed.
module alu16_rr_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic last_reg;
   logic held_reg;

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = last_reg ? 2'b01 : 2'b10;
      end
   end

   // held_reg remembers who was granted until the response is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_reg <= 1'b1;
         held_reg <= 1'b0;
      end else begin
         if (|gnt) begin
            held_reg <= gnt[1];
         end
         if (advance) begin
            last_reg <= held_reg;
         end
      end
   end

endmodule

// File: rtl/alu16_sched.sv
// Schedules 16/32-bit requests from two requesters onto one external 16-bit ALU.
// Wide operations take a low pass then a high pass with the carry chained between them.
module alu16_sched #(
   parameter int NUM_REQ = alu16_sched_pkg::NUM_REQ
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [1:0][31:0] req_a,
   input  logic [1:0][31:0] req_b,
   input  logic [1:0][3:0]  req_opcode,
   input  logic [1:0]       req_mode,
   input  logic [1:0]       req_cin,
   input  logic [1:0]       req_wide,
   output logic [15:0]      alu_a,
   output logic [15:0]      alu_b,
   output logic [3:0]       alu_opcode,
   output logic             alu_mode,
   output logic             alu_cin,
   input  logic [15:0]      alu_result,
   input  logic             alu_cout,
   input  logic             alu_nbo,
   input  logic             alu_ngo,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [31:0]      rsp_result,
   output logic             rsp_cout,
   output logic             rsp_nbo,
   output logic             rsp_ngo,
   output logic             busy
);

   import alu16_sched_pkg::*;

   state_t             state_reg, state_next;
   req_t               op_reg;
   req_t               in_sel;
   logic               id_reg;
   logic [31:0]        res_reg;
   logic               cout_reg, nbo_reg, ngo_reg;
   logic [NUM_REQ-1:0] arb_req, gnt;
   logic               hs, rsp_hs, sel;

   // Requests are only offered to the arbiter in IDLE and never while reset is held.
   assign arb_req = (state_reg == IDLE && rst_n) ? req_valid : '0;
   assign hs      = |gnt;
   assign rsp_hs  = (state_reg == RESP) && rsp_ready;
   assign sel     = gnt[1];

   alu16_rr_arb u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (arb_req),
      .advance (rsp_hs),
      .gnt     (gnt)
   );

   always_comb begin
      in_sel.a      = req_a[sel];
      in_sel.b      = req_b[sel];
      in_sel.opcode = req_opcode[sel];
      in_sel.mode   = req_mode[sel];
      in_sel.cin    = req_cin[sel];
      in_sel.wide   = req_wide[sel];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         op_reg    <= '0;
         id_reg    <= 1'b0;
         res_reg   <= '0;
         cout_reg  <= 1'b0;
         nbo_reg   <= 1'b0;
         ngo_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (hs) begin
            op_reg <= in_sel;
            id_reg <= sel;
         end
         if (state_reg == LO) begin
            res_reg  <= {16'h0000, alu_result};
            cout_reg <= alu_cout;
            nbo_reg  <= alu_nbo;
            ngo_reg  <= alu_ngo;
         end
         if (state_reg == HI) begin
            res_reg[31:16] <= alu_result;
            cout_reg       <= alu_cout;
            nbo_reg        <= alu_nbo;
            ngo_reg        <= alu_ngo;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      req_ready  = '0;
      alu_a      = '0;
      alu_b      = '0;
      alu_opcode = '0;
      alu_mode   = 1'b0;
      alu_cin    = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = gnt;
            if (hs) state_next = LO;
         end
         LO: begin
            alu_a      = op_reg.a[15:0];
            alu_b      = op_reg.b[15:0];
            alu_opcode = op_reg.opcode;
            alu_mode   = op_reg.mode;
            alu_cin    = op_reg.cin;
            state_next = op_reg.wide ? HI : RESP;
         end
         HI: begin
            alu_a      = op_reg.a[31:16];
            alu_b      = op_reg.b[31:16];
            alu_opcode = op_reg.opcode;
            alu_mode   = op_reg.mode;
            alu_cin    = cout_reg;
            state_next = RESP;
         end
         RESP: begin
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign rsp_valid  = (state_reg == RESP);
   assign rsp_result = rsp_valid ? res_reg : '0;
   assign rsp_id     = rsp_valid & id_reg;
   assign rsp_cout   = rsp_valid & cout_reg;
   assign rsp_nbo    = rsp_valid & nbo_reg;
   assign rsp_ngo    = rsp_valid & ngo_reg;
   assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu16_sched.sv
// Directed bench for alu16_sched with an adder ALU stub and a response scoreboard.
module tb_alu16_sched;

   typedef struct packed {
      logic        id;
      logic [31:0] res;
      logic        cout;
      logic        nbo;
      logic        ngo;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [1:0]       req_valid = '0;
   logic [1:0]       req_ready;
   logic [1:0][31:0] req_a = '0;
   logic [1:0][31:0] req_b = '0;
   logic [1:0][3:0]  req_opcode = '0;
   logic [1:0]       req_mode = '0;
   logic [1:0]       req_cin = '0;
   logic [1:0]       req_wide = '0;
   logic [15:0]      alu_a, alu_b, alu_result;
   logic [3:0]       alu_opcode;
   logic             alu_mode, alu_cin, alu_cout, alu_nbo, alu_ngo;
   logic             rsp_valid, rsp_id, rsp_cout, rsp_nbo, rsp_ngo, busy;
   logic             rsp_ready = 1'b0;
   logic [31:0]      rsp_result;

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   // ALU stub: add with carry; nbo = result sign, ngo = result is zero.
   assign {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0000, alu_cin};
   assign alu_nbo = alu_result[15];
   assign alu_ngo = (alu_result == 16'h0000);

   always #5 clk = ~clk;

   alu16_sched #(.NUM_REQ(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
      .req_mode(req_mode), .req_cin(req_cin), .req_wide(req_wide),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_mode(alu_mode), .alu_cin(alu_cin),
      .alu_result(alu_result), .alu_cout(alu_cout), .alu_nbo(alu_nbo), .alu_ngo(alu_ngo),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_nbo(rsp_nbo), .rsp_ngo(rsp_ngo),
      .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input int id, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic wide);
      exp_t        e;
      logic [32:0] s;
      logic [16:0] t;
      e.id = id[0];
      if (wide) begin
         s = {1'b0, a} + {1'b0, b} + {32'h0, cin};
         e.res  = s[31:0];
         e.cout = s[32];
         e.nbo  = s[31];
         e.ngo  = (s[31:16] == 16'h0000);
      end else begin
         t = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'h0, cin};
         e.res  = {16'h0000, t[15:0]};
         e.cout = t[16];
         e.nbo  = t[15];
         e.ngo  = (t[15:0] == 16'h0000);
      end
      return e;
   endfunction

   task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic wide);
      req_a[id]      = a;
      req_b[id]      = b;
      req_cin[id]    = cin;
      req_wide[id]   = wide;
      req_opcode[id] = 4'h9;
      req_mode[id]   = 1'b0;
   endtask

   // One transaction from request to response handshake; hold = cycles of rsp backpressure.
   task automatic run_txn(input int id, input bit keep, input int hold);
      int          n;
      exp_t        e;
      logic        wide;
      logic [31:0] a;
      logic [16:0] lo;
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("one_ready", $countones(req_ready), 1);
      chk("gnt_id", {31'h0, req_ready[id]}, 1);
      sb.push_back(model(id, req_a[id], req_b[id], req_cin[id], req_wide[id]));
      wide = req_wide[id];
      a    = req_a[id];
      lo   = {1'b0, req_a[id][15:0]} + {1'b0, req_b[id][15:0]} + {16'h0, req_cin[id]};
      @(posedge clk);
      #1;
      if (!keep) req_valid[id] = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            chk("lo_alu_a", {16'h0, alu_a}, {16'h0, a[15:0]});
            chk("lo_opcode", {28'h0, alu_opcode}, 32'h9);
         end
         if (n == 2 && wide) begin
            chk("hi_alu_a", {16'h0, alu_a}, {16'h0, a[31:16]});
            chk("hi_alu_cin", {31'h0, alu_cin}, {31'h0, lo[16]});
         end
      end while (!rsp_valid && n < 10);
      chk("latency", n, wide ? 3 : 2);
      for (int k = 0; k < hold; k++) begin
         chk("bp_result", rsp_result, sb[0].res);
         chk("bp_valid", {31'h0, rsp_valid}, 1);
         chk("bp_ready0", {30'h0, req_ready}, 0);
         chk("bp_busy", {31'h0, busy}, 1);
         @(negedge clk);
      end
      e = sb.pop_front();
      chk("rsp_id", {31'h0, rsp_id}, {31'h0, e.id});
      chk("rsp_result", rsp_result, e.res);
      chk("rsp_flags", {29'h0, rsp_cout, rsp_nbo, rsp_ngo}, {29'h0, e.cout, e.nbo, e.ngo});
      chk("resp_alu_a", {16'h0, alu_a}, 0);
      $display("[TB] rsp id=%0d result=%h cout=%0d nbo=%0d ngo=%0d latency=%0d",
               rsp_id, rsp_result, rsp_cout, rsp_nbo, rsp_ngo, n);
      rsp_ready = 1'b1;
      #1;
      chk("no_accept_in_resp", {30'h0, req_ready}, 0);
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state, with requests pending that must not be acknowledged.
      req_valid = 2'b11;
      #1;
      chk("rst_ready", {30'h0, req_ready}, 0);
      chk("rst_busy", {31'h0, busy}, 0);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 0);
      chk("rst_alu_a", {16'h0, alu_a}, 0);
      req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Narrow op on requester 0.
      set_req(0, 32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0);
      req_valid = 2'b01;
      run_txn(0, 0, 0);

      // Wide op with carry from the low pass into the high pass.
      set_req(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1);
      req_valid = 2'b10;
      run_txn(1, 0, 0);

      // Contention: both held valid for four operations.
      set_req(0, 32'hABCD_8000, 32'h0000_8000, 1'b0, 1'b0);
      set_req(1, 32'h1234_F000, 32'h0001_2000, 1'b1, 1'b1);
      req_valid = 2'b11;
      run_txn(0, 1, 0);
      run_txn(1, 1, 0);
      run_txn(0, 1, 0);
      run_txn(1, 1, 0);
      req_valid = 2'b00;

      // Backpressure with requester 1 still waiting.
      set_req(0, 32'h7FFF_7FFF, 32'h0000_0001, 1'b0, 1'b1);
      set_req(1, 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0);
      req_valid = 2'b11;
      run_txn(0, 0, 5);
      req_valid = 2'b00;

      // Reset while in the high pass of a wide op.
      set_req(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1);
      req_valid = 2'b10;
      #1;
      chk("abort_ready", {30'h0, req_ready}, 2);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk);
      chk("abort_hi_busy", {31'h0, busy}, 1);
      chk("abort_hi_cin", {31'h0, alu_cin}, 1);
      #1;
      rst_n = 1'b0;
      req_valid = 2'b11;
      #1;
      chk("abort_busy", {31'h0, busy}, 0);
      chk("abort_ready0", {30'h0, req_ready}, 0);
      chk("abort_alu", {alu_a, alu_b}, 0);
      chk("abort_alu_ctl", {26'h0, alu_opcode, alu_mode, alu_cin}, 0);
      chk("abort_rsp", {rsp_result[30:0], rsp_valid}, 0);
      chk("abort_rsp_flags", {28'h0, rsp_id, rsp_cout, rsp_nbo, rsp_ngo}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 2'b00;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("no_rsp_after_abort", {30'h0, busy, rsp_valid}, 0);
      end

      // First contention after reset must go to requester 0.
      set_req(0, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
      set_req(1, 32'h0000_0030, 32'h0000_0040, 1'b0, 1'b0);
      req_valid = 2'b11;
      run_txn(0, 0, 0);
      req_valid = 2'b00;

      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
